// File: rtl/timer_seq_pkg.sv
// Shared definitions for the interval-timer tick sequencer: FSM states,
// timer register map, control bit positions and fixed write data.
package timer_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_WAIT,
    S_CLR,
    S_WR_STOP,
    S_STOP_CLR,
    S_WR_SNAP,
    S_RD_SL,
    S_RD_SH,
    S_SNAP_DONE
  } state_t;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] CLR_DATA  = 16'h0000;
  localparam logic [15:0] STOP_DATA = 16'(1 << CTRL_STOP);

  // Control word that arms the timer: interrupt enabled, started, optional reload.
  function automatic logic [15:0] ctrl_run_word(input logic cont);
    logic [15:0] w;
    w              = '0;
    w[CTRL_ITO]    = 1'b1;
    w[CTRL_CONT]   = cont;
    w[CTRL_START]  = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_tick_sequencer.sv
// Bus master that programs the interval timer, services its timeouts into
// one-cycle ticks, and fetches counter snapshots on request.
module timer_tick_sequencer
  import timer_seq_pkg::*;
#(
  parameter int MIN_PERIOD = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cfg_period,
  input  logic             cfg_continuous,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic             cfg_snap,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             snap_valid,
  output logic [31:0]      snap_value,
  output logic             cfg_err,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
  input  logic             tmr_irq
);

  localparam logic [31:0] LP_MIN_PERIOD = 32'(MIN_PERIOD);

  state_t           r_state;
  logic [31:0]      r_period;
  logic             r_cont;
  logic             r_tick;
  logic [CNT_W-1:0] r_tick_count;
  logic             r_snap_valid;
  logic [15:0]      r_snap_lo;
  logic [31:0]      r_snap_value;
  logic             r_cfg_err;

  logic [2:0]       w_addr;
  logic             w_cs;
  logic             w_wr_n;
  logic [15:0]      w_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_period     <= '0;
      r_cont       <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
      r_snap_valid <= 1'b0;
      r_snap_lo    <= '0;
      r_snap_value <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_tick       <= 1'b0;
      r_snap_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_period >= LP_MIN_PERIOD) begin
              r_period     <= cfg_period;
              r_cont       <= cfg_continuous;
              r_tick_count <= '0;
              r_cfg_err    <= 1'b0;
              r_state      <= S_WR_PL;
            end else begin
              r_cfg_err    <= 1'b1;
            end
          end
        end
        S_WR_PL:   r_state <= S_WR_PH;
        S_WR_PH:   r_state <= S_WR_CTRL;
        S_WR_CTRL: r_state <= S_WAIT;
        S_WAIT: begin
          if (cfg_stop) begin
            r_state <= S_WR_STOP;
          end else if (tmr_irq) begin
            r_state <= S_CLR;
            r_tick  <= 1'b1;
          end else if (cfg_snap) begin
            r_state <= S_WR_SNAP;
          end
        end
        S_CLR: begin
          r_tick_count <= r_tick_count + CNT_W'(1);
          r_state      <= r_cont ? S_WAIT : S_IDLE;
        end
        S_WR_STOP:  r_state <= S_STOP_CLR;
        S_STOP_CLR: r_state <= S_IDLE;
        S_WR_SNAP:  r_state <= S_RD_SL;
        S_RD_SL:    r_state <= S_RD_SH;
        S_RD_SH: begin
          r_snap_lo    <= tmr_readdata;
          r_snap_valid <= 1'b1;
          r_state      <= S_SNAP_DONE;
        end
        S_SNAP_DONE: begin
          r_snap_value <= {tmr_readdata, r_snap_lo};
          r_state      <= S_WAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus strobes depend on the state register alone; no input reaches the bus.
  always_comb begin
    w_addr  = ADDR_STATUS;
    w_cs    = 1'b0;
    w_wr_n  = 1'b1;
    w_wdata = '0;
    case (r_state)
      S_WR_PL: begin
        w_addr = ADDR_PERIOD_L; w_cs = 1'b1; w_wr_n = 1'b0; w_wdata = r_period[15:0];
      end
      S_WR_PH: begin
        w_addr = ADDR_PERIOD_H; w_cs = 1'b1; w_wr_n = 1'b0; w_wdata = r_period[31:16];
      end
      S_WR_CTRL: begin
        w_addr = ADDR_CONTROL; w_cs = 1'b1; w_wr_n = 1'b0; w_wdata = ctrl_run_word(r_cont);
      end
      S_CLR, S_STOP_CLR: begin
        w_addr = ADDR_STATUS; w_cs = 1'b1; w_wr_n = 1'b0; w_wdata = CLR_DATA;
      end
      S_WR_STOP: begin
        w_addr = ADDR_CONTROL; w_cs = 1'b1; w_wr_n = 1'b0; w_wdata = STOP_DATA;
      end
      S_WR_SNAP: begin
        w_addr = ADDR_SNAP_L; w_cs = 1'b1; w_wr_n = 1'b0;
      end
      S_RD_SL: begin
        w_addr = ADDR_SNAP_L; w_cs = 1'b1;
      end
      S_RD_SH: begin
        w_addr = ADDR_SNAP_H; w_cs = 1'b1;
      end
      default: ;
    endcase
  end

  assign tmr_address    = w_addr;
  assign tmr_chipselect = w_cs;
  assign tmr_write_n    = w_wr_n;
  assign tmr_writedata  = w_wdata;

  assign busy       = (r_state != S_IDLE);
  assign tick       = r_tick;
  assign tick_count = r_tick_count;
  assign snap_valid = r_snap_valid;
  assign cfg_err    = r_cfg_err;
  // High half arrives in the pulse cycle, so it is forwarded straight through then.
  assign snap_value = (r_state == S_SNAP_DONE) ? {tmr_readdata, r_snap_lo} : r_snap_value;

endmodule
